// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// Exhaustive stimulus/checker engine for a combinational function of N_IN
// inputs. On start it walks every input combination (binary or Gray order),
// holds each vector for HOLD_CYCLES clocks, samples dut_f on the last cycle of
// the dwell and compares it with EXPECTED[vec_out]. The sweep reports the
// number of mismatching vectors and the first failing vector.
//
// Ports
//   clk              in   system clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   start            in   one-cycle sweep request, honoured in IDLE only
//   gray_mode        in   0 = binary order, 1 = Gray order (latched at start)
//   dut_f            in   output of the function under test
//   vec_out          out  [N_IN-1:0] registered vector to the DUT, MSB = input A
//   busy             out  high for the whole sweep (2**N_IN * HOLD_CYCLES cycles)
//   sample_strobe    out  high on the cycle dut_f is sampled
//   done             out  one-cycle pulse at the end of the sweep
//   err_count        out  [N_IN:0] mismatching vectors in the last sweep
//   first_err_valid  out  a mismatch has been recorded
//   first_err_vec    out  [N_IN-1:0] vec_out of the first mismatch
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int                      N_IN        = 4,
    parameter int                      HOLD_CYCLES = 20,
    parameter logic [(1<<N_IN)-1:0]    EXPECTED    = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            gray_mode,
    input  logic            dut_f,
    output logic [N_IN-1:0] vec_out,
    output logic            busy,
    output logic            sample_strobe,
    output logic            done,
    output logic [N_IN:0]   err_count,
    output logic            first_err_valid,
    output logic [N_IN-1:0] first_err_vec
);

    localparam int              HOLD_W    = $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0] IDX_LAST  = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [N_IN-1:0]     idx_q, idx_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                gray_q, gray_d;
    logic [N_IN-1:0]     vec_q, vec_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [N_IN:0]       err_q, err_d;
    logic                fev_valid_q, fev_valid_d;
    logic [N_IN-1:0]     fev_q, fev_d;

    logic                strobe;
    logic [N_IN-1:0]     idx_inc;
    logic [N_IN-1:0]     vec_next;

    // Sequence position -> vector value. In Gray mode consecutive vectors
    // differ in exactly one input bit.
    function automatic logic [N_IN-1:0] map_vec(input logic [N_IN-1:0] idx,
                                                 input logic            use_gray);
        return use_gray ? (idx ^ (idx >> 1)) : idx;
    endfunction

    assign idx_inc  = idx_q + 1'b1;
    assign vec_next = map_vec(idx_inc, gray_q);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        gray_d      = gray_q;
        vec_d       = vec_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        fev_valid_d = fev_valid_q;
        fev_d       = fev_q;
        strobe      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    idx_d       = '0;
                    hold_d      = '0;
                    gray_d      = gray_mode;
                    vec_d       = '0;
                    busy_d      = 1'b1;
                    err_d       = '0;
                    fev_valid_d = 1'b0;
                    fev_d       = '0;
                end
            end

            S_RUN: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_LAST) begin
                    strobe = 1'b1;
                    hold_d = '0;
                    // Expected bit is selected by the vector value itself,
                    // so Gray ordering needs no table remapping.
                    if (dut_f != EXPECTED[vec_q]) begin
                        err_d = err_q + 1'b1;
                        if (!fev_valid_q) begin
                            fev_valid_d = 1'b1;
                            fev_d       = vec_q;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        // Last vector stays on vec_out after the sweep.
                        state_d = S_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_inc;
                        vec_d = vec_next;
                    end
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            hold_q      <= '0;
            gray_q      <= 1'b0;
            vec_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= '0;
            fev_valid_q <= 1'b0;
            fev_q       <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            gray_q      <= gray_d;
            vec_q       <= vec_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            fev_valid_q <= fev_valid_d;
            fev_q       <= fev_d;
        end
    end

    assign vec_out         = vec_q;
    assign busy            = busy_q;
    assign sample_strobe   = strobe;
    assign done            = done_q;
    assign err_count       = err_q;
    assign first_err_valid = fev_valid_q;
    assign first_err_vec   = fev_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// Testbench for truth_table_sweeper. Two instances:
//   dut_a : N_IN=2, HOLD_CYCLES=3, EXPECTED=4'b1000, DUT function selectable
//           (AND / NAND / OR) from vec_a.
//   dut_b : defaults with EXPECTED=16'hA5C3, DUT = table 16'hA583 (bit 6 flipped).
// Every launched sweep pushes its expected strobe events and final result into
// a per-instance queue; a monitor pops and compares on each strobe/done.
// -----------------------------------------------------------------------------
module tb_truth_table_sweeper;

    typedef struct {
        bit is_done;
        int vec;
        int cyc;
        int err;
        int valid;
        int first;
        int busy_n;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic gray = 1'b0;

    logic [1:0] vec_a;
    logic       busy_a, strobe_a, done_a, fev_valid_a, dut_f_a;
    logic [2:0] err_a;
    logic [1:0] fev_a;

    logic [3:0] vec_b;
    logic       busy_b, strobe_b, done_b, fev_valid_b, dut_f_b;
    logic [4:0] err_b;
    logic [3:0] fev_b;

    int         fn_sel = 0;             // 0 AND, 1 NAND, 2 OR
    logic [15:0] bad_tbl = 16'hA583;

    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;
    int busy_cnt_a = 0;
    int busy_cnt_b = 0;
    exp_t qa[$];
    exp_t qb[$];

    // Gray order for 4 bits; the first four entries are the 2-bit order.
    int gray4 [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        case (fn_sel)
            0:       dut_f_a = vec_a[1] & vec_a[0];
            1:       dut_f_a = ~(vec_a[1] & vec_a[0]);
            default: dut_f_a = vec_a[1] | vec_a[0];
        endcase
    end
    assign dut_f_b = bad_tbl[vec_b];

    truth_table_sweeper #(.N_IN(2), .HOLD_CYCLES(3), .EXPECTED(4'b1000)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .gray_mode(gray),
        .dut_f(dut_f_a), .vec_out(vec_a), .busy(busy_a),
        .sample_strobe(strobe_a), .done(done_a), .err_count(err_a),
        .first_err_valid(fev_valid_a), .first_err_vec(fev_a)
    );

    truth_table_sweeper #(.EXPECTED(16'hA5C3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .gray_mode(gray),
        .dut_f(dut_f_b), .vec_out(vec_b), .busy(busy_b),
        .sample_strobe(strobe_b), .done(done_b), .err_count(err_b),
        .first_err_valid(fev_valid_b), .first_err_vec(fev_b)
    );

    task automatic chk(input string name, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    endtask

    task automatic fail_evt(input string name);
        n_total++;
        $display("FAIL %s: unexpected event at cycle %0d, expected none", name, cyc);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        exp_t x;
        if (!rst_n) begin
            qa.delete();
            busy_cnt_a = 0;
        end else begin
            if (busy_a) busy_cnt_a++;
            if (strobe_a || done_a) begin
                if (qa.size() == 0) fail_evt("a_event");
                else begin
                    x = qa.pop_front();
                    chk("a_event_kind", int'(done_a), int'(x.is_done));
                    chk("a_event_cycle", cyc, x.cyc);
                    if (!x.is_done) begin
                        chk("a_vec", int'(vec_a), x.vec);
                        $display("a strobe  cyc=%0d vec=%0d f=%0d", cyc, vec_a, dut_f_a);
                    end else begin
                        chk("a_err_count", int'(err_a), x.err);
                        chk("a_first_valid", int'(fev_valid_a), x.valid);
                        chk("a_first_vec", int'(fev_a), x.first);
                        chk("a_busy_cycles", busy_cnt_a, x.busy_n);
                        chk("a_busy_at_done", int'(busy_a), 0);
                        $display("a done    cyc=%0d err=%0d first_valid=%0d first=%0d",
                                 cyc, err_a, fev_valid_a, fev_a);
                    end
                end
                if (done_a) busy_cnt_a = 0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t x;
        if (!rst_n) begin
            qb.delete();
            busy_cnt_b = 0;
        end else begin
            if (busy_b) busy_cnt_b++;
            if (strobe_b || done_b) begin
                if (qb.size() == 0) fail_evt("b_event");
                else begin
                    x = qb.pop_front();
                    chk("b_event_kind", int'(done_b), int'(x.is_done));
                    chk("b_event_cycle", cyc, x.cyc);
                    if (!x.is_done) begin
                        chk("b_vec", int'(vec_b), x.vec);
                        $display("b strobe  cyc=%0d vec=%0d f=%0d", cyc, vec_b, dut_f_b);
                    end else begin
                        chk("b_err_count", int'(err_b), x.err);
                        chk("b_first_valid", int'(fev_valid_b), x.valid);
                        chk("b_first_vec", int'(fev_b), x.first);
                        chk("b_busy_cycles", busy_cnt_b, x.busy_n);
                        chk("b_busy_at_done", int'(busy_b), 0);
                        $display("b done    cyc=%0d err=%0d first_valid=%0d first=%0d",
                                 cyc, err_b, fev_valid_b, fev_b);
                    end
                end
                if (done_b) busy_cnt_b = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Pulse start for one cycle and queue the whole expected sweep. gray is
    // flipped right after start to show it is latched.
    task automatic launch(input bit big, input bit g, input int exp_err,
                          input int exp_first, input int exp_valid);
        int n, hold, e;
        exp_t x;
        n    = big ? 16 : 4;
        hold = big ? 20 : 3;
        @(posedge clk);
        #1;
        if (big) start_b = 1'b1; else start_a = 1'b1;
        gray = g;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        gray    = ~g;
        e       = cyc;
        for (int i = 0; i < n; i++) begin
            x.is_done = 1'b0;
            x.vec     = g ? gray4[i] : i;
            x.cyc     = e + hold - 1 + i * hold;
            x.err = 0; x.valid = 0; x.first = 0; x.busy_n = 0;
            if (big) qb.push_back(x); else qa.push_back(x);
        end
        x.is_done = 1'b1;
        x.vec     = 0;
        x.cyc     = e + n * hold;
        x.err     = exp_err;
        x.valid   = exp_valid;
        x.first   = exp_first;
        x.busy_n  = n * hold;
        if (big) qb.push_back(x); else qa.push_back(x);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && (qa.size() != 0 || qb.size() != 0); i++)
            @(negedge clk);
        if (qa.size() != 0 || qb.size() != 0) begin
            n_total++;
            $display("FAIL sweep_timeout: %0d/%0d events outstanding, expected 0",
                     qa.size(), qb.size());
            qa.delete();
            qb.delete();
        end
        #1;
    endtask

    initial begin
        // Reset (edge generated explicitly so the async path is exercised).
        #2 rst_n = 1'b0;
        #2;
        chk("rst_vec", int'(vec_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_strobe", int'(strobe_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_err", int'(err_a), 0);
        chk("rst_first_valid", int'(fev_valid_a), 0);
        chk("rst_first_vec", int'(fev_a), 0);
        chk("rst_b_busy", int'(busy_b), 0);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;

        // AND, binary: all match.
        fn_sel = 0;
        launch(1'b0, 1'b0, 0, 0, 0);
        wait_done();

        // NAND, binary, with a stray start at cycle 5: every vector fails.
        fn_sel = 1;
        launch(1'b0, 1'b0, 4, 0, 1);
        repeat (4) @(posedge clk);
        #1 start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        wait_done();
        repeat (10) @(negedge clk);
        chk("hold_err", int'(err_a), 4);
        chk("hold_first_valid", int'(fev_valid_a), 1);
        chk("hold_first_vec", int'(fev_a), 0);

        // AND, Gray: comparison indexed by vector value, results cleared at start.
        fn_sel = 0;
        launch(1'b0, 1'b1, 0, 0, 0);
        chk("clear_err", int'(err_a), 0);
        chk("clear_first_valid", int'(fev_valid_a), 0);
        wait_done();

        // OR, binary, aborted by reset at cycle 7.
        fn_sel = 2;
        launch(1'b0, 1'b0, 2, 1, 1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_vec", int'(vec_a), 0);
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_err", int'(err_a), 0);
        chk("abort_first_valid", int'(fev_valid_a), 0);
        chk("abort_first_vec", int'(fev_a), 0);
        chk("abort_strobe", int'(strobe_a), 0);
        chk("abort_done", int'(done_a), 0);
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1'b1;
        repeat (20) @(negedge clk);   // any done here is flagged by the monitor

        // OR, binary, full sweep after reset: vectors 1 and 2 fail.
        launch(1'b0, 1'b0, 2, 1, 1);
        wait_done();

        // Default-size instance: only vector 6 is wrong, in either order.
        launch(1'b1, 1'b0, 1, 6, 1);
        wait_done();
        launch(1'b1, 1'b1, 1, 6, 1);
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Parametrised, synthesizable exhaustive stimulus and checker engine for combinational lab functions of N_IN inputs.
- Walks every input combination, holds each for a programmable dwell, and samples the DUT output at the end of the dwell.
- Compares each sample against an expected truth table and reports mismatch count and first failing vector.
- Replaces hand-written per-vector stimulus; supports binary or Gray ordering.

Parameters:
- N_IN, 4, number of DUT inputs; legal range 1..8.
- HOLD_CYCLES, 20, clock cycles each vector is driven; minimum 2.
- EXPECTED, 16'h0000, width 2**N_IN; bit k is the expected DUT output when vec_out == k.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a sweep; sampled in IDLE only
- gray_mode  input  1  0 = binary order, 1 = Gray order; latched at start
- dut_f  input  1  DUT output under test
- vec_out  output  N_IN  vector driven to DUT inputs, MSB = first input (A)
- busy  output  1  high from the cycle after start until the cycle done pulses
- sample_strobe  output  1  one-cycle pulse on the cycle dut_f is sampled
- done  output  1  one-cycle pulse when the sweep completes
- err_count  output  N_IN+1  number of mismatching vectors in the last sweep
- first_err_valid  output  1  at least one mismatch has been recorded
- first_err_vec  output  N_IN  vec_out value of the first mismatch

Behaviour:
- Reset values (asynchronous, rst_n low): state IDLE; vec_out 0, busy 0, sample_strobe 0, done 0, err_count 0, first_err_valid 0, first_err_vec 0; internal index and hold counter 0.
- States:
  - IDLE: wait for start.
  - RUN: drive the current vector and count the dwell.
  - FIN: one cycle; pulse done.
- IDLE -> RUN on start==1, registered at edge k. On the same edge:
  - index <= 0, hold counter <= 0.
  - err_count, first_err_valid and first_err_vec clear.
  - gray_mode latches.
  - From edge k onward, vec_out = f(0) = 0 and busy = 1.
- Vector mapping: f(i) = i in binary mode, or i ^ (i >> 1) in Gray mode. vec_out is registered, not combinational.
- RUN dwell:
  - The hold counter increments each cycle.
  - When hold == HOLD_CYCLES-1, sample_strobe = 1 for that cycle and dut_f is compared with EXPECTED[vec_out]. The index is the vector value, not the sequence position.
  - On mismatch, err_count increments. If first_err_valid is 0, set it to 1 and capture first_err_vec = vec_out.
  - At the same edge, the hold counter resets to 0 and the index increments, so vec_out updates.
- After the sample for index 2**N_IN - 1: RUN -> FIN. vec_out holds its last value.
- FIN: done = 1 for one cycle and busy falls to 0 on the same edge; then -> IDLE.
- Total sweep length: 2**N_IN × HOLD_CYCLES cycles of busy, then the done pulse.
- Results (err_count, first_err_valid, first_err_vec) hold stable in IDLE until the next start.
- start while in RUN or FIN is ignored; there is no restart and no queuing.
- gray_mode changes after start have no effect on the running sweep.
- err_count saturates naturally: its maximum value 2**N_IN fits in N_IN+1 bits.
- Reset mid-sweep aborts immediately to the reset values; no done pulse is generated.
- The DUT is combinational; settle time is HOLD_CYCLES-1 cycles before sampling.

Test Plan:
- N_IN=2, HOLD_CYCLES=3, EXPECTED=4'b1000, DUT = AND of vec_out bits, binary mode, start pulsed at cycle 0:
  - vec_out follows 00,01,10,11, each held 3 cycles.
  - sample_strobe fires at cycles 3,6,9,12.
  - done pulses at cycle 13 with err_count=0 and first_err_valid=0.
- Same setup, DUT = NAND:
  - err_count=4, first_err_valid=1, first_err_vec=2'b00.
- Same setup, gray_mode=1, DUT = AND:
  - vec_out sequence is 00,01,11,10.
  - err_count=0, because comparison is indexed by vector value.
- Start pulsed again at cycle 5 of a running sweep:
  - Sequence and timing are unchanged and done pulses exactly once, at cycle 13.
  - After done, results hold until a new start, which clears them.
- rst_n driven low at cycle 7 mid-sweep:
  - All outputs go to 0 asynchronously, before the next clock edge.
  - No done pulse occurs.
  - A subsequent start runs a full, correct sweep.
- Defaults (N_IN=4, HOLD_CYCLES=20, EXPECTED=16'hA5C3), DUT = table lookup of 16'hA5C3 with bit 6 flipped:
  - 16 vectors over 320 busy cycles.
  - err_count=1, first_err_vec=4'b0110.
